// File: rtl/encoder_odometry.sv
// Multi-channel quadrature encoder odometry: synchronizes and glitch-filters A/B,
// decodes steps into wrapping position counters and windowed, saturated velocity.
module encoder_odometry #(
  parameter int NUM_CH     = 2,
  parameter int CNT_W      = 20,
  parameter int VEL_W      = 16,
  parameter int FILT_LEN   = 4,
  parameter int WIN_CYCLES = 500000
) (
  input  logic                      clk_50M,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         enc_a,
  input  logic [NUM_CH-1:0]         enc_b,
  input  logic [NUM_CH-1:0]         clear,
  output logic [NUM_CH*CNT_W-1:0]   position,
  output logic [NUM_CH*VEL_W-1:0]   velocity,
  output logic                      vel_valid,
  output logic [NUM_CH-1:0]         dir,
  output logic [NUM_CH-1:0]         err
);

  localparam int WIN_W     = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
  localparam int ACC_MIN_W = $clog2(WIN_CYCLES + 1) + 1;
  // Accumulator must hold a full window of same-direction steps without wrapping.
  localparam int ACC_W     = (ACC_MIN_W > VEL_W + 1) ? ACC_MIN_W : VEL_W + 1;
  localparam int FCNT_W    = 4;

  localparam logic signed [ACC_W-1:0] VMAX = {{(ACC_W-VEL_W+1){1'b0}}, {(VEL_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] VMIN = {{(ACC_W-VEL_W+1){1'b1}}, {(VEL_W-1){1'b0}}};

  logic [WIN_W-1:0] win_cnt;
  logic             win_tc;

  assign win_tc = (win_cnt == WIN_W'(WIN_CYCLES - 1));

  always_ff @(posedge clk_50M or negedge reset) begin
    if (!reset) begin
      win_cnt   <= '0;
      vel_valid <= 1'b0;
    end else begin
      win_cnt   <= win_tc ? '0 : win_cnt + WIN_W'(1);
      vel_valid <= win_tc;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [1:0]              sync1, sync2, filt, filt_d;
    logic [FCNT_W-1:0]       fcnt [2];
    logic                    step_fwd, step_rev, step_bad;
    logic [CNT_W-1:0]        pos_q;
    logic [VEL_W-1:0]        vel_q;
    logic signed [ACC_W-1:0] acc_q, acc_sum;
    logic [VEL_W-1:0]        vel_sat;
    logic                    dir_q, err_q;

    always_ff @(posedge clk_50M or negedge reset) begin
      if (!reset) begin
        sync1  <= 2'b00;
        sync2  <= 2'b00;
        filt   <= 2'b00;
        filt_d <= 2'b00;
        fcnt   <= '{default: '0};
      end else begin
        sync1  <= {enc_a[i], enc_b[i]};
        sync2  <= sync1;
        filt_d <= filt;
        for (int k = 0; k < 2; k++) begin
          if (sync2[k] != filt[k]) begin
            if (fcnt[k] == FCNT_W'(FILT_LEN - 1)) begin
              filt[k] <= sync2[k];
              fcnt[k] <= '0;
            end else begin
              fcnt[k] <= fcnt[k] + FCNT_W'(1);
            end
          end else begin
            fcnt[k] <= '0;
          end
        end
      end
    end

    // {prev, cur} Gray-code decode; both bits flipping together is an illegal jump.
    always_comb begin
      step_fwd = 1'b0;
      step_rev = 1'b0;
      step_bad = 1'b0;
      case ({filt_d, filt})
        4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_fwd = 1'b1;
        4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: step_rev = 1'b1;
        4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: step_bad = 1'b1;
        default: ;
      endcase
    end

    always_comb begin
      acc_sum = acc_q;
      if (step_fwd)      acc_sum = acc_q + ACC_W'(1);
      else if (step_rev) acc_sum = acc_q - ACC_W'(1);
      if (acc_sum > VMAX)      vel_sat = VMAX[VEL_W-1:0];
      else if (acc_sum < VMIN) vel_sat = VMIN[VEL_W-1:0];
      else                     vel_sat = acc_sum[VEL_W-1:0];
    end

    always_ff @(posedge clk_50M or negedge reset) begin
      if (!reset) begin
        pos_q <= '0;
        vel_q <= '0;
        acc_q <= '0;
        dir_q <= 1'b1;
        err_q <= 1'b0;
      end else begin
        if (clear[i])      pos_q <= '0;
        else if (step_fwd) pos_q <= pos_q + CNT_W'(1);
        else if (step_rev) pos_q <= pos_q - CNT_W'(1);

        if (clear[i])      err_q <= 1'b0;
        else if (step_bad) err_q <= 1'b1;

        if (step_fwd)      dir_q <= 1'b1;
        else if (step_rev) dir_q <= 1'b0;

        if (win_tc) begin
          vel_q <= vel_sat;
          acc_q <= '0;
        end else begin
          acc_q <= acc_sum;
        end
      end
    end

    assign position[i*CNT_W +: CNT_W] = pos_q;
    assign velocity[i*VEL_W +: VEL_W] = vel_q;
    assign dir[i] = dir_q;
    assign err[i] = err_q;
  end

endmodule

// File: tb/tb_encoder_odometry.sv
// Scoreboard bench for encoder_odometry: two instances sharing stimulus, one with
// narrow position/velocity widths to exercise wrap and saturation.
module tb_encoder_odometry;

  logic        clk_50M = 1'b0;
  logic        rst_n;
  logic [1:0]  enc_a, enc_b, clear;
  logic [39:0] pos_a;
  logic [31:0] vel_a;
  logic        vv_a;
  logic [1:0]  dir_a, err_a;
  logic [7:0]  pos_b;
  logic [7:0]  vel_b;
  logic        vv_b;
  logic [1:0]  dir_b, err_b;

  encoder_odometry #(.NUM_CH(2), .CNT_W(20), .VEL_W(16), .FILT_LEN(4), .WIN_CYCLES(100)) dut_a (
    .clk_50M(clk_50M), .reset(rst_n), .enc_a(enc_a), .enc_b(enc_b), .clear(clear),
    .position(pos_a), .velocity(vel_a), .vel_valid(vv_a), .dir(dir_a), .err(err_a));

  encoder_odometry #(.NUM_CH(2), .CNT_W(4), .VEL_W(4), .FILT_LEN(4), .WIN_CYCLES(100)) dut_b (
    .clk_50M(clk_50M), .reset(rst_n), .enc_a(enc_a), .enc_b(enc_b), .clear(clear),
    .position(pos_b), .velocity(vel_b), .vel_valid(vv_b), .dir(dir_b), .err(err_b));

  always #10 clk_50M = ~clk_50M;

  typedef struct { string name; int kind; int exp; } chk_t;
  typedef struct { int cyc; int va; int vb; } vel_t;

  chk_t chk_q[$];
  vel_t vel_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   vel_phase = 0;
  int   idx = 0;
  logic [1:0] seq [4];

  always @(posedge clk_50M) cyc <= cyc + 1;

  function automatic int actual(int kind);
    case (kind)
      0: return 32'(signed'(pos_a[19:0]));
      1: return 32'(signed'(pos_a[39:20]));
      2: return 32'(dir_a);
      3: return 32'(err_a);
      4: return 32'(signed'(pos_b[3:0]));
      5: return 32'({vv_b, vv_a});
      6: return 32'(signed'(vel_a[15:0]));
      7: return 32'(signed'(vel_b[3:0]));
      8: return 32'(signed'(vel_a[31:16]));
      9: return vel_q.size();
      default: return -9999;
    endcase
  endfunction

  task automatic cmp(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: drains pending state expectations and matches every vel_valid pulse.
  always @(negedge clk_50M) begin
    chk_t c;
    vel_t v;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      cmp(c.name, actual(c.kind), c.exp);
    end
    if (vel_phase && (vv_a || vv_b)) begin
      if (vel_q.size() == 0) begin
        cmp("vel_unexpected", 1, 0);
      end else begin
        v = vel_q.pop_front();
        cmp("vel_time", cyc, v.cyc);
        cmp("vel_both_valid", 32'({vv_b, vv_a}), 3);
        cmp("vel_a_ch0", actual(6), v.va);
        cmp("vel_b_ch0", actual(7), v.vb);
        cmp("vel_a_ch1", actual(8), 0);
      end
    end
  end

  task automatic expect_v(string name, int kind, int exp);
    chk_t c;
    c.name = name; c.kind = kind; c.exp = exp;
    chk_q.push_back(c);
  endtask

  task automatic expect_vel(int at, int va, int vb);
    vel_t v;
    v.cyc = at; v.va = va; v.vb = vb;
    vel_q.push_back(v);
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk_50M);
      #1;
    end
  endtask

  task automatic set_ab(logic [1:0] ab);
    enc_a[0] = ab[1];
    enc_b[0] = ab[0];
  endtask

  task automatic fwd(int hold);
    idx = (idx + 1) % 4;
    set_ab(seq[idx]);
    tick(hold);
  endtask

  task automatic rev(int hold);
    idx = (idx + 3) % 4;
    set_ab(seq[idx]);
    tick(hold);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1;
    seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b11; seq[3] = 2'b10;
    rst_n = 1'b0; enc_a = '0; enc_b = '0; clear = '0;

    #5;
    expect_v("rst_pos0", 0, 0);
    expect_v("rst_pos1", 1, 0);
    expect_v("rst_dir", 2, 3);
    expect_v("rst_err", 3, 0);
    expect_v("rst_vel", 6, 0);
    expect_v("rst_vv", 5, 0);
    tick(2);
    rst_n = 1'b1;
    tick(3);

    // forward quadrature cycle, 10 cycles per level
    repeat (4) fwd(10);
    expect_v("fwd_pos0", 0, 4);
    expect_v("fwd_dir", 2, 3);
    expect_v("fwd_err", 3, 0);
    expect_v("fwd_pos1", 1, 0);

    // short pulses rejected, 4-cycle level accepted
    set_ab(2'b10); tick(1); set_ab(2'b00); tick(10);
    expect_v("pulse1_pos", 0, 4);
    set_ab(2'b10); tick(3); set_ab(2'b00); tick(10);
    expect_v("pulse3_pos", 0, 4);
    expect_v("pulse3_err", 3, 0);
    set_ab(2'b10); tick(4); set_ab(2'b00); tick(4);
    expect_v("stable4_pos", 0, 3);
    expect_v("stable4_dir", 2, 2);
    tick(10);
    expect_v("stable4_back_pos", 0, 4);
    expect_v("stable4_back_dir", 2, 3);

    // illegal double-bit jump, then clear
    set_ab(2'b11); idx = 2; tick(10);
    expect_v("illegal_err", 3, 1);
    expect_v("illegal_pos", 0, 4);
    clear[0] = 1'b1; tick(1); clear[0] = 1'b0; tick(2);
    expect_v("clear_err", 3, 0);
    expect_v("clear_pos", 0, 0);
    expect_v("clear_dir", 2, 3);

    // clear lands on the same edge as a step
    idx = 3; set_ab(seq[idx]); tick(6);
    clear[0] = 1'b1; tick(1); clear[0] = 1'b0; tick(3);
    expect_v("clear_step_pos", 0, 0);

    // pin-to-position latency
    idx = 0; set_ab(seq[idx]); tick(6);
    expect_v("latency_early", 0, 0);
    tick(1);
    expect_v("latency_on_time", 0, 1);
    tick(5);

    // narrow counter wrap
    repeat (6) fwd(10);
    expect_v("wrap_pre_b", 4, 7);
    fwd(10);
    expect_v("wrap_fwd_b", 4, -8);
    expect_v("wrap_fwd_a", 0, 8);
    rev(10);
    expect_v("wrap_rev_b", 4, 7);
    expect_v("wrap_rev_dir", 2, 2);
    expect_v("wrap_err", 3, 0);

    // velocity windows from a clean reset
    idx = 0; set_ab(seq[idx]); tick(10);
    rst_n = 1'b0; tick(2);
    rst_n = 1'b1;
    c0 = cyc;
    vel_phase = 1;
    expect_vel(c0 + 100, 30, 7);
    expect_vel(c0 + 200, -30, -8);
    tick(5);
    repeat (30) fwd(2);
    tick(c0 + 105 - cyc);
    repeat (30) rev(2);
    tick(c0 + 205 - cyc);
    repeat (5) fwd(2);
    tick(c0 + 250 - cyc);

    // reset mid-window with a non-empty accumulator
    #4;
    rst_n = 1'b0;
    expect_v("midrst_pos0", 0, 0);
    expect_v("midrst_pos_b", 4, 0);
    expect_v("midrst_dir", 2, 3);
    expect_v("midrst_err", 3, 0);
    expect_v("midrst_vel_a", 6, 0);
    expect_v("midrst_vel_b", 7, 0);
    expect_v("midrst_vv", 5, 0);
    idx = 0; set_ab(seq[idx]);
    tick(2);
    rst_n = 1'b1;
    c1 = cyc;
    expect_vel(c1 + 100, 3, 3);
    tick(5);
    repeat (3) fwd(2);
    tick(c1 + 110 - cyc);
    expect_v("vel_missing", 9, 0);
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
